sram_responder: RTL

Synthesizable responder model of the external 16-bit asynchronous SRAM at the pin level. It is the device end of the SRAM pin bus that our memory-stage SRAM controller drives: it answers address, chip/output/write/byte-lane enables and the bidirectional data bus. It is used in simulation benches and FPGA loopback builds in place of the physical SRAM. It adds a configurable read-latency pipeline, access counters and an address-range monitor.

---
 rtl/sram_responder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
//
// Pin-level responder for the external 16-bit asynchronous SRAM. It sits at the
// device end of the SRAM pin bus and answers the memory-stage controller. It
// stands in for the physical part in simulation benches and FPGA loopback
// builds. On top of the plain SRAM behaviour it offers:
//   - an optional read-latency pipeline (READ_LAT clk cycles; 0 = combinational)
//   - saturating write/read access counters
//   - a sticky monitor for addresses beyond the implemented depth
//
// Parameters:
//   DEPTH_LOG2  implemented word-address bits (1..18); 2^DEPTH_LOG2 words
//   READ_LAT    read latency in clk cycles (0..3); 0 = asynchronous read
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   SRAM_ADDR  word address; bits above DEPTH_LOG2 are ignored, so they alias
//   SRAM_DQ    bidirectional data bus; driven per byte lane on reads, else Z
//   SRAM_CE_N  chip enable, active low
//   SRAM_OE_N  output enable, active low
//   SRAM_WE_N  write enable, active low; takes priority over OE_N
//   SRAM_UB_N  upper byte lane (DQ[15:8]) enable, active low
//   SRAM_LB_N  lower byte lane (DQ[7:0]) enable, active low
//   wr_count   write edges with at least one lane enabled, saturating
//   rd_count   read edges, saturating
//   addr_oor   sticky flag: an out-of-range address was accessed
// -----------------------------------------------------------------------------
module sram_responder #(
   parameter int DEPTH_LOG2 = 10,
   parameter int READ_LAT   = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [17:0] SRAM_ADDR,
   inout  wire  [15:0] SRAM_DQ,
   input  logic        SRAM_CE_N,
   input  logic        SRAM_OE_N,
   input  logic        SRAM_WE_N,
   input  logic        SRAM_UB_N,
   input  logic        SRAM_LB_N,
   output logic [15:0] wr_count,
   output logic [15:0] rd_count,
   output logic        addr_oor
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DEPTH_LOG2-1:0] index;
   logic                  write_edge;
   logic                  read_edge;
   logic                  lane_any;
   logic [15:0]           rd_data;
   logic                  rd_valid;
   logic                  drive;

   logic [15:0] mem [DEPTH];

   assign index      = SRAM_ADDR[DEPTH_LOG2-1:0];
   assign write_edge = !SRAM_CE_N && !SRAM_WE_N;
   assign read_edge  = !SRAM_CE_N &&  SRAM_WE_N && !SRAM_OE_N;
   assign lane_any   = !SRAM_UB_N || !SRAM_LB_N;

   // ---------------------------------------------------------------------------
   // Storage with byte-lane writes
   // ---------------------------------------------------------------------------
   // NOTE: the array has no reset branch on purpose; contents survive rst and a
   // reset on a large array would stop it mapping onto block RAM.
   always_ff @(posedge clk) begin
      if (write_edge) begin
         // NOTE: non-blocking assignments for all clocked state, so every reader
         // on this edge (pipeline capture, counters) sees the pre-edge values.
         if (!SRAM_UB_N) mem[index][15:8] <= SRAM_DQ[15:8];
         if (!SRAM_LB_N) mem[index][7:0]  <= SRAM_DQ[7:0];
      end
   end

   // ---------------------------------------------------------------------------
   // Read path
   // ---------------------------------------------------------------------------
   if (READ_LAT == 0) begin : g_async_read
      // Fully combinational: DQ follows ADDR and the enables with no clocking.
      assign rd_data  = mem[index];
      assign rd_valid = 1'b1;
   end else begin : g_pipe_read
      logic                capture;
      logic [READ_LAT-1:0] pipe_valid;
      logic [15:0]         pipe_data [READ_LAT];

      // Capture ignores OE_N so a controller can open OE_N late and still get
      // the word addressed READ_LAT edges earlier.
      assign capture = !SRAM_CE_N && SRAM_WE_N;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            pipe_valid <= '0;
         end else begin
            pipe_valid[0] <= capture;
            for (int i = 1; i < READ_LAT; i++) begin
               pipe_valid[i] <= pipe_valid[i-1];
            end
         end
      end

      // Data shifts every edge; the valid bits alone decide whether it is used.
      always_ff @(posedge clk) begin
         pipe_data[0] <= mem[index];
         for (int i = 1; i < READ_LAT; i++) begin
            pipe_data[i] <= pipe_data[i-1];
         end
      end

      assign rd_data  = pipe_data[READ_LAT-1];
      assign rd_valid = pipe_valid[READ_LAT-1];
   end

   // Reset forces the bus to Z at once, even mid-read.
   assign drive = !rst && read_edge && rd_valid;

   assign SRAM_DQ[15:8] = (drive && !SRAM_UB_N) ? rd_data[15:8] : 8'hzz;
   assign SRAM_DQ[7:0]  = (drive && !SRAM_LB_N) ? rd_data[7:0]  : 8'hzz;

   // ---------------------------------------------------------------------------
   // Saturating access counters
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_count <= '0;
         rd_count <= '0;
      end else begin
         if (write_edge && lane_any && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'd1;
         end
         if (read_edge && (rd_count != 16'hFFFF)) begin
            rd_count <= rd_count + 16'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Out-of-range address monitor
   // ---------------------------------------------------------------------------
   if (DEPTH_LOG2 < 18) begin : g_oor
      logic high_bits_set;

      assign high_bits_set = |SRAM_ADDR[17:DEPTH_LOG2];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            addr_oor <= 1'b0;
         end else if (!SRAM_CE_N && high_bits_set) begin
            addr_oor <= 1'b1;
         end
      end
   end else begin : g_no_oor
      // Every address bit is implemented, so nothing can be out of range.
      assign addr_oor = 1'b0;
   end

endmodule
